// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO for the E stage; results land MULT_CYCLES/DIV_CYCLES edges after start.
// Divider present only when MDU_DIV_EN is defined; otherwise div/divu behave as bubbles.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_D,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [3:0]    r_op;

  logic          w_busy;
  logic          w_is_mul;
  logic          w_is_div;
  logic          w_start;
  logic          w_done;
  logic          w_wr;
  logic [63:0]   w_res;
  logic [63:0]   w_prod_s;
  logic [63:0]   w_prod_u;

  assign w_busy   = (r_state == S_RUN);
  assign w_is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MDU_DIV_EN
  assign w_is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
`else
  assign w_is_div = 1'b0;
`endif
  assign w_start  = (w_is_mul || w_is_div) && !w_busy;
  assign w_done   = w_busy && (r_cnt == CW'(1));

  // Result is formed from the latched operands in the final busy cycle.
  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

`ifdef MDU_DIV_EN
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quo_u;
  logic [31:0] w_rem_u;

  // SV signed '/' and '%' already truncate toward zero with dividend-signed remainder.
  assign w_quo_s = $signed(r_a) / $signed(r_b);
  assign w_rem_s = $signed(r_a) % $signed(r_b);
  assign w_quo_u = r_a / r_b;
  assign w_rem_u = r_a % r_b;
`endif

  always_comb begin
    w_res = w_prod_u;
    w_wr  = 1'b1;
    case (r_op)
      OP_MULT:  w_res = w_prod_s;
      OP_MULTU: w_res = w_prod_u;
`ifdef MDU_DIV_EN
      OP_DIV: begin
        w_res = {w_rem_s, w_quo_s};
        w_wr  = (r_b != 32'd0);
      end
      OP_DIVU: begin
        w_res = {w_rem_u, w_quo_u};
        w_wr  = (r_b != 32'd0);
      end
`endif
      default: w_res = w_prod_u;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_RUN;
      S_RUN:  if (w_done)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_a   <= a;
        r_b   <= b;
        r_op  <= md_op;
        r_cnt <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (w_busy) begin
        r_cnt <= r_cnt - CW'(1);
      end
      // Moves to HI/LO are only honoured while idle.
      if (w_done) begin
        if (w_wr) begin
          r_hi <= w_res[63:32];
          r_lo <= w_res[31:0];
        end
      end else if (!w_busy) begin
        if (md_op == OP_MTHI) r_hi <= a;
        if (md_op == OP_MTLO) r_lo <= a;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (md_op)
      OP_MFHI: rdata = r_hi;
      OP_MFLO: rdata = r_lo;
      default: rdata = 32'd0;
    endcase
  end

  assign busy     = w_busy;
  assign md_stall = md_use_D && (w_busy || w_start);
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit and its HI/LO scheduler for the pipelined MIPS core. It sits in the E stage beside the ALU and executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo. It models multi-cycle latency with a busy counter and owns the HI/LO registers. It gives the hazard unit the stall term that holds any later multiply/divide-class instruction in D until HI/LO are valid.

## Interface
Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu; must be ≥1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- md_op  in  4  E-stage operation: 0 none/bubble, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 treated as 0.
- a  in  32  forwarded rs value (E stage).
- b  in  32  forwarded rt value (E stage).
- md_use_D  in  1  D-stage instruction is any of the eight md-class instructions.
- busy  out  1  operation in progress.
- md_stall  out  1  stall request to the hazard unit.
- hi  out  32  HI register.
- lo  out  32  LO register.
- rdata  out  32  mfhi → hi, mflo → lo, otherwise 0; combinational.

## Operation
- start = (md_op ∈ {1..4}) & ~busy.
- On start: latch a, b and the op; load counter with MULT_CYCLES or DIV_CYCLES; busy←1.
- While busy: counter decrements each edge. On the edge where the counter goes 1→0:
  - busy←0.
  - The latched result is written to HI/LO.
- mult/multu: 64-bit product, signed/unsigned; hi←[63:32], lo←[31:0].
- div/divu: signed/unsigned quotient → lo, remainder → hi.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divisor 0: HI/LO unchanged, but the full DIV_CYCLES busy period still runs.
- mthi/mtlo when ~busy: hi←a or lo←a at the next edge.
- Any md_op 1–6 arriving while busy: ignored; state unchanged.
  - The hazard unit makes this unreachable; the bench checks it anyway.
- mfhi/mflo: rdata reflects current hi/lo; the value is stale if busy.
- md_stall = md_use_D & (busy | start). It is combinational from registered busy and the E-stage md_op.
- States: IDLE (busy=0) and RUN (busy=1, counter = remaining cycles). Counter width is clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

## Timing
- Reset values: hi=0, lo=0, busy=0, counter=0, latched operands/op=0. md_stall=0 and rdata=0 given md_op=0.
- Start sampled at edge E0 (end of cycle T).
  - busy=1 for cycles T+1 … T+N.
  - HI/LO update at the edge ending cycle T+N, and busy falls at that same edge.
  - The result is visible in cycle T+N+1.
- A new start is accepted in cycle T+N+1, which gives back-to-back operations with no gap.
- mthi/mtlo: one-edge latency.
- Reset asserted mid-RUN: at the next edge busy←0, counter←0, hi/lo←0. The pending result is discarded and never written.
- reset and start in the same cycle: reset wins.

## Configuration
- MDU_DIV_EN defined: div/divu behave as above. A divider (combinational at start, or iterative within DIV_CYCLES) is instantiated.
- MDU_DIV_EN undefined:
  - No divider logic.
  - md_op 3/4 treated as 0: no start, no busy, HI/LO unchanged, md_stall contribution 0.
  - The DIV_CYCLES parameter is unused.

## Test plan
- Reset: hold reset 2 cycles → hi=0, lo=0, busy=0, md_stall=0, rdata=0.
- mult, a=0xFFFFFFFE, b=3, MULT_CYCLES=5:
  - busy=1 for exactly 5 cycles.
  - Afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Repeat as multu → hi=0x00000002, lo=0xFFFFFFFA.
- div, a=0xFFFFFFF9 (-7), b=2, md_use_D=1 throughout:
  - md_stall=1 in the start cycle and all 10 busy cycles, then 0.
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu on the same operands → lo=0x7FFFFFFC, hi=0x00000001.
- divu by 0, with hi=0x1234 set beforehand via mthi:
  - busy lasts 10 cycles; hi=0x1234 and lo are unchanged afterwards.
  - mfhi → rdata=0x00001234.
- mtlo 0xABCD issued during busy (after a mult start) → ignored; lo equals the mult result when busy falls.
- Reset asserted in the 3rd busy cycle of mult 5×7:
  - Next edge: busy=0, hi=lo=0.
  - 10 further cycles: no write of 35 occurs.
  - Rebuilt without MDU_DIV_EN, a div → busy stays 0.
